cva6_rvfi_trace_buffer: RTL and testbench
=========================================

Name: cva6_rvfi_trace_buffer

Overview:
- Multi-port retirement trace buffer between the commit stage and the RVFI trace consumer (tracer / co-simulation bridge).
- Accepts up to NrPorts retired-instruction records per cycle and stamps each with a global 64-bit retirement order number.
- Serialises records in program order through a FIFO onto one valid/ready output.
- Detects and accounts for overflow without silent loss of ordering information.

Parameters:
- NrPorts, 2, number of commit ports feeding records per cycle (1..4).
- Depth, 16, FIFO entries; power of two, Depth >= 2*NrPorts.
- RecWidth, 128, width of the opaque per-record payload (insn, pc, rd, wdata, trap...).
- CntWidth, 16, width of the dropped-record counter.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- commit_valid_i  in  NrPorts  per-port record valid; port 0 is oldest.
- commit_rec_i  in  NrPorts*RecWidth  per-port payload; port i at [i*RecWidth +: RecWidth].
- trace_valid_o  out  1  output record valid.
- trace_ready_i  in  1  consumer accepts record.
- trace_rec_o  out  RecWidth  output payload.
- trace_order_o  out  64  retirement order number of output record.
- trace_port_o  out  $clog2(NrPorts) (min 1)  commit port the record came from.
- overflow_o  out  1  sticky: at least one commit group was dropped.
- drop_cnt_o  out  CntWidth  number of records dropped; saturating.
- clear_ovf_i  in  1  clears overflow_o and drop_cnt_o.
- empty_o  out  1  FIFO holds no records.

Behaviour:
- Reset (async, rst_ni low):
  - FIFO pointers and count = 0.
  - Order counter = 0.
  - overflow_o = 0, drop_cnt_o = 0.
  - trace_valid_o = 0, empty_o = 1.
  - Payload storage is not reset.
  - Reset mid-operation discards all buffered records immediately.
- Group: the set of ports with commit_valid_i high in one cycle; k = popcount (0..NrPorts).
  - Valid ports are compacted in ascending port index; gaps (e.g. ports 0 and 2 valid) are allowed.
  - Compacted entry j receives order = order_q + j.
- Order counter:
  - Advances by k every cycle k > 0, whether the group is accepted or dropped, so drops appear as gaps in trace_order_o.
  - 64-bit wrap-around modulo 2^64.
- Accept rule:
  - Free = Depth - count_q, evaluated before this cycle's pop; a same-cycle pop does not create space.
  - If k <= free: all k records are written at wptr, wptr+1, ... (mod Depth). Count increases by k (minus 1 if a pop occurs).
  - If k > free: the whole group is dropped; no partial writes.
    - overflow_o set the next cycle.
    - drop_cnt_o += k, saturating at all-ones.
- Output:
  - Registered FIFO, no fall-through. A record written in cycle N is first visible at the output in cycle N+1 at the earliest.
  - trace_valid_o = (count_q != 0).
  - trace_rec_o / trace_order_o / trace_port_o show the head entry and stay stable while valid && !ready.
  - Pop occurs when trace_valid_o && trace_ready_i; rptr advances by 1 (mod Depth).
- Simultaneous push and pop: both take effect. count_n = count_q + k_accepted - pop.
- clear_ovf_i:
  - Clears overflow_o and drop_cnt_o next cycle.
  - If a drop happens in the same cycle, the drop wins: overflow_o = 1 and drop_cnt_o = k.
- empty_o = (count_q == 0).
- Pointers: log2(Depth) bits with natural wrap. Count is log2(Depth)+1 bits; full when count == Depth.
- Sequencing: no combinational path from trace_ready_i to any output except through registered state.

Test Plan:
- NrPorts=2: ports 0 and 1 valid with recs A, B after reset, ready=1 -> A with order 0 / port 0 at cycle 1, B with order 1 / port 1 at cycle 2; empty_o=1 at cycle 3.
- Only port 1 valid (rec C), then port 0 valid (rec D) -> C order 0 port 1, D order 1 port 0; compaction leaves no holes in the FIFO.
- ready=0 and Depth=16: 8 cycles of 2-record groups fill the FIFO to count 16; a 9th group of 2 -> dropped, overflow_o=1 next cycle, drop_cnt_o=2. Then ready=1 -> 16 records drain with orders 0..15; the next accepted group starts at order 18.
- count=15 with one pop and a 2-record group in the same cycle -> group dropped (pop not counted as free space); drop_cnt_o += 2; count becomes 14.
- clear_ovf_i pulsed alone -> overflow_o=0, drop_cnt_o=0. Pulsed in the same cycle as a 1-record drop -> overflow_o=1, drop_cnt_o=1.
- Assert rst_ni low while count=5 and valid=1 -> trace_valid_o=0, empty_o=1 immediately. After release, the first record carries order 0.

Source files
------------

// File: rtl/cva6_rvfi_trace_buffer.sv
// ---------------------------------------------------------------------------
// cva6_rvfi_trace_buffer
//
// Retirement trace buffer between the commit stage and the RVFI trace
// consumer. Each cycle up to NrPorts retired records arrive. The valid ones
// are compacted in ascending port order and stamped with a 64-bit retirement
// order number. They are then serialised through a registered FIFO onto a
// single valid/ready stream.
//
// A group that does not fit in the FIFO is dropped as a whole. The order
// counter still advances past it, so a drop shows up as a gap in
// trace_order_o. It is also recorded in a sticky overflow flag and in a
// saturating drop counter.
//
// Ports:
//   clk_i, rst_ni    clock, asynchronous active-low reset
//   commit_valid_i   per-port record valid, port 0 oldest
//   commit_rec_i     per-port payload, port i at [i*RecWidth +: RecWidth]
//   trace_valid_o    head record valid
//   trace_ready_i    consumer accepts the head record
//   trace_rec_o      head payload
//   trace_order_o    head retirement order number
//   trace_port_o     commit port the head record came from
//   overflow_o       sticky: at least one group was dropped
//   drop_cnt_o       number of dropped records, saturating
//   clear_ovf_i      clears overflow_o / drop_cnt_o (a same-cycle drop wins)
//   empty_o          FIFO holds no records
// ---------------------------------------------------------------------------
module cva6_rvfi_trace_buffer #(
  parameter int unsigned NrPorts  = 2,
  parameter int unsigned Depth    = 16,
  parameter int unsigned RecWidth = 128,
  parameter int unsigned CntWidth = 16
) (
  input  logic                                             clk_i,
  input  logic                                             rst_ni,
  input  logic [NrPorts-1:0]                               commit_valid_i,
  input  logic [NrPorts*RecWidth-1:0]                      commit_rec_i,
  output logic                                             trace_valid_o,
  input  logic                                             trace_ready_i,
  output logic [RecWidth-1:0]                              trace_rec_o,
  output logic [63:0]                                      trace_order_o,
  output logic [((NrPorts > 1) ? $clog2(NrPorts) : 1)-1:0] trace_port_o,
  output logic                                             overflow_o,
  output logic [CntWidth-1:0]                              drop_cnt_o,
  input  logic                                             clear_ovf_i,
  output logic                                             empty_o
);

  localparam int unsigned PortW  = (NrPorts > 1) ? $clog2(NrPorts) : 1;
  localparam int unsigned PtrW   = $clog2(Depth);
  localparam int unsigned CountW = PtrW + 1;

  typedef logic [PtrW-1:0]   ptr_t;
  typedef logic [CountW-1:0] cnt_t;

  // State
  ptr_t                wptr_q, wptr_d;
  ptr_t                rptr_q, rptr_d;
  cnt_t                count_q, count_d;
  logic [63:0]         order_q, order_d;
  logic                ovf_q, ovf_d;
  logic [CntWidth-1:0] drop_cnt_q, drop_cnt_d;

  // Payload storage, deliberately not reset
  logic [RecWidth-1:0] rec_mem_q   [Depth];
  logic [63:0]         order_mem_q [Depth];
  logic [PortW-1:0]    port_mem_q  [Depth];

  // Group decode
  cnt_t                grp_k;
  ptr_t                slot   [NrPorts];
  ptr_t                widx   [NrPorts];
  cnt_t                free_slots;
  logic                accept;
  logic                drop;
  logic                pop;
  logic [CntWidth:0]   drop_sum;
  logic [CntWidth-1:0] drop_base;

  // Per-entry write decode
  logic                mem_we  [Depth];
  logic [PortW-1:0]    mem_src [Depth];

  // Compaction: each valid port takes the slot equal to the number of valid
  // ports below it, so the group lands contiguously at wptr.
  always_comb begin
    grp_k = '0;
    for (int unsigned i = 0; i < NrPorts; i++) begin
      slot[i] = grp_k[PtrW-1:0];
      widx[i] = wptr_q + grp_k[PtrW-1:0];
      if (commit_valid_i[i]) begin
        grp_k = grp_k + cnt_t'(1);
      end
    end
  end

  // Free space is taken before this cycle's pop; a pop never makes room.
  assign free_slots = cnt_t'(Depth) - count_q;
  assign accept     = (grp_k <= free_slots);
  assign drop       = ~accept;
  assign pop        = trace_valid_o & trace_ready_i;

  always_comb begin
    for (int unsigned e = 0; e < Depth; e++) begin
      mem_we[e]  = 1'b0;
      mem_src[e] = '0;
      for (int unsigned i = 0; i < NrPorts; i++) begin
        if (accept && commit_valid_i[i] && (widx[i] == ptr_t'(e))) begin
          mem_we[e]  = 1'b1;
          mem_src[e] = PortW'(i);
        end
      end
    end
  end

  // Pointer, count and order-counter next state
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    // The order counter advances for dropped groups too.
    order_d = order_q + 64'(grp_k);
    if (accept) begin
      wptr_d  = wptr_q + grp_k[PtrW-1:0];
      count_d = count_d + grp_k;
    end
    if (pop) begin
      rptr_d  = rptr_q + ptr_t'(1);
      count_d = count_d - cnt_t'(1);
    end
  end

  // Overflow accounting; a drop in the same cycle as a clear wins.
  always_comb begin
    drop_base  = clear_ovf_i ? '0 : drop_cnt_q;
    drop_sum   = {1'b0, drop_base} + (CntWidth + 1)'(grp_k);
    ovf_d      = ovf_q;
    drop_cnt_d = drop_cnt_q;
    if (drop) begin
      ovf_d      = 1'b1;
      drop_cnt_d = drop_sum[CntWidth] ? '1 : drop_sum[CntWidth-1:0];
    end else if (clear_ovf_i) begin
      ovf_d      = 1'b0;
      drop_cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      order_q    <= '0;
      ovf_q      <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      order_q    <= order_d;
      ovf_q      <= ovf_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  for (genvar e = 0; e < Depth; e++) begin : g_entry
    always_ff @(posedge clk_i) begin
      if (mem_we[e]) begin
        rec_mem_q[e]   <= commit_rec_i[mem_src[e]*RecWidth +: RecWidth];
        order_mem_q[e] <= order_q + 64'(slot[mem_src[e]]);
        port_mem_q[e]  <= mem_src[e];
      end
    end
  end

  // Outputs depend only on registered state.
  assign trace_valid_o = (count_q != '0);
  assign empty_o       = (count_q == '0);
  assign trace_rec_o   = rec_mem_q[rptr_q];
  assign trace_order_o = order_mem_q[rptr_q];
  assign trace_port_o  = port_mem_q[rptr_q];
  assign overflow_o    = ovf_q;
  assign drop_cnt_o    = drop_cnt_q;

endmodule

// File: tb/tb_cva6_rvfi_trace_buffer.sv
// ---------------------------------------------------------------------------
// Testbench for cva6_rvfi_trace_buffer (NrPorts=2, Depth=16).
// A queue-based reference model is checked against the DUT every cycle on
// the falling clock edge. Directed literal checks pin key expected values.
// ---------------------------------------------------------------------------
module tb_cva6_rvfi_trace_buffer;

  localparam int NrPorts  = 2;
  localparam int Depth    = 16;
  localparam int RecWidth = 128;
  localparam int CntWidth = 16;

  logic                        clk_i;
  logic                        rst_ni;
  logic [NrPorts-1:0]          commit_valid_i;
  logic [NrPorts*RecWidth-1:0] commit_rec_i;
  logic                        trace_valid_o;
  logic                        trace_ready_i;
  logic [RecWidth-1:0]         trace_rec_o;
  logic [63:0]                 trace_order_o;
  logic [0:0]                  trace_port_o;
  logic                        overflow_o;
  logic [CntWidth-1:0]         drop_cnt_o;
  logic                        clear_ovf_i;
  logic                        empty_o;

  cva6_rvfi_trace_buffer #(
    .NrPorts (NrPorts),
    .Depth   (Depth),
    .RecWidth(RecWidth),
    .CntWidth(CntWidth)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .commit_valid_i(commit_valid_i),
    .commit_rec_i  (commit_rec_i),
    .trace_valid_o (trace_valid_o),
    .trace_ready_i (trace_ready_i),
    .trace_rec_o   (trace_rec_o),
    .trace_order_o (trace_order_o),
    .trace_port_o  (trace_port_o),
    .overflow_o    (overflow_o),
    .drop_cnt_o    (drop_cnt_o),
    .clear_ovf_i   (clear_ovf_i),
    .empty_o       (empty_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [127:0]    rec;
    longint unsigned order;
    int              port;
  } ent_t;

  ent_t            mq[$];
  longint unsigned m_order;
  bit              m_ovf;
  int              m_drop;

  int n_cmp = 0;
  int n_err = 0;
  bit done  = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [127:0] mkrec(input int n);
    logic [63:0] hi;
    logic [63:0] lo;
    hi = 64'hABCD_0000_0000_0000 + 64'(n);
    lo = 64'(n) * 64'd7 + 64'h5555;
    return {hi, lo};
  endfunction

  task automatic model_reset();
    mq.delete();
    m_order = 0;
    m_ovf   = 1'b0;
    m_drop  = 0;
  endtask

  // Behavioural model of one clock edge, using the inputs held across it.
  task automatic model_update();
    int  k;
    int  free;
    int  j;
    bit  do_pop;
    int  base;
    ent_t e;
    if (!rst_ni) return;
    k = 0;
    for (int i = 0; i < NrPorts; i++) if (commit_valid_i[i]) k++;
    free   = Depth - mq.size();
    do_pop = (mq.size() != 0) && trace_ready_i;
    if (k <= free) begin
      j = 0;
      for (int i = 0; i < NrPorts; i++) begin
        if (commit_valid_i[i]) begin
          e.rec   = commit_rec_i[i*RecWidth +: RecWidth];
          e.order = m_order + longint'(j);
          e.port  = i;
          mq.push_back(e);
          j++;
        end
      end
      if (clear_ovf_i) begin
        m_ovf  = 1'b0;
        m_drop = 0;
      end
    end else begin
      base   = clear_ovf_i ? 0 : m_drop;
      m_drop = (base + k > 65535) ? 65535 : base + k;
      m_ovf  = 1'b1;
    end
    if (do_pop) void'(mq.pop_front());
    m_order = m_order + longint'(k);
  endtask

  task automatic step(input logic [1:0] v, input logic [127:0] r0, input logic [127:0] r1,
                      input logic rdy, input logic clr);
    commit_valid_i = v;
    commit_rec_i   = {r1, r0};
    trace_ready_i  = rdy;
    clear_ovf_i    = clr;
    @(posedge clk_i);
    model_update();
    @(negedge clk_i);
  endtask

  // Compare process: DUT against model on every falling edge.
  initial begin
    while (!done) begin
      @(negedge clk_i);
      if (done) break;
      chk("valid", 128'(trace_valid_o), 128'(mq.size() != 0));
      chk("empty", 128'(empty_o), 128'(mq.size() == 0));
      chk("overflow", 128'(overflow_o), 128'(m_ovf));
      chk("drop_cnt", 128'(drop_cnt_o), 128'(m_drop));
      if (mq.size() != 0) begin
        chk("head_rec", trace_rec_o, mq[0].rec);
        chk("head_order", 128'(trace_order_o), 128'(mq[0].order));
        chk("head_port", 128'(trace_port_o), 128'(mq[0].port));
      end
    end
  end

  localparam logic [127:0] Z = '0;

  initial begin
    rst_ni         = 1'b0;
    commit_valid_i = '0;
    commit_rec_i   = '0;
    trace_ready_i  = 1'b0;
    clear_ovf_i    = 1'b0;
    model_reset();
    @(negedge clk_i);
    @(negedge clk_i);
    chk("reset_valid", 128'(trace_valid_o), 128'd0);
    chk("reset_empty", 128'(empty_o), 128'd1);
    chk("reset_ovf", 128'(overflow_o), 128'd0);
    chk("reset_drop", 128'(drop_cnt_o), 128'd0);
    rst_ni = 1'b1;

    // Two-record group, ready high: A then B, then empty.
    step(2'b11, mkrec(1), mkrec(2), 1'b1, 1'b0);
    chk("a_rec", trace_rec_o, mkrec(1));
    chk("a_order", 128'(trace_order_o), 128'd0);
    chk("a_port", 128'(trace_port_o), 128'd0);
    step(2'b00, Z, Z, 1'b1, 1'b0);
    chk("b_rec", trace_rec_o, mkrec(2));
    chk("b_order", 128'(trace_order_o), 128'd1);
    chk("b_port", 128'(trace_port_o), 128'd1);
    step(2'b00, Z, Z, 1'b1, 1'b0);
    chk("ab_empty", 128'(empty_o), 128'd1);

    // Gapped groups: port 1 only, then port 0 only.
    step(2'b10, Z, mkrec(3), 1'b0, 1'b0);
    step(2'b01, mkrec(4), Z, 1'b0, 1'b0);
    chk("c_order", 128'(trace_order_o), 128'd2);
    chk("c_port", 128'(trace_port_o), 128'd1);
    step(2'b00, Z, Z, 1'b1, 1'b0);
    chk("d_rec", trace_rec_o, mkrec(4));
    chk("d_order", 128'(trace_order_o), 128'd3);
    chk("d_port", 128'(trace_port_o), 128'd0);
    step(2'b00, Z, Z, 1'b1, 1'b0);
    chk("cd_empty", 128'(empty_o), 128'd1);

    // Fill to full with ready low, then overflow with a 9th group.
    for (int i = 0; i < 8; i++) step(2'b11, mkrec(10 + 2*i), mkrec(11 + 2*i), 1'b0, 1'b0);
    chk("full_no_ovf", 128'(overflow_o), 128'd0);
    step(2'b11, mkrec(90), mkrec(91), 1'b0, 1'b0);
    chk("ovf_set", 128'(overflow_o), 128'd1);
    chk("ovf_drop2", 128'(drop_cnt_o), 128'd2);
    chk("full_head", 128'(trace_order_o), 128'd4);
    for (int i = 0; i < 16; i++) step(2'b00, Z, Z, 1'b1, 1'b0);
    chk("drained", 128'(empty_o), 128'd1);
    step(2'b11, mkrec(30), mkrec(31), 1'b1, 1'b0);
    chk("gap_order", 128'(trace_order_o), 128'd22);
    step(2'b00, Z, Z, 1'b1, 1'b0);
    step(2'b00, Z, Z, 1'b1, 1'b0);

    // count=15, pop plus 2-record group in one cycle: group dropped.
    for (int i = 0; i < 7; i++) step(2'b11, mkrec(40 + 2*i), mkrec(41 + 2*i), 1'b0, 1'b0);
    step(2'b01, mkrec(60), Z, 1'b0, 1'b0);
    step(2'b11, mkrec(61), mkrec(62), 1'b1, 1'b0);
    chk("pop_drop_cnt", 128'(drop_cnt_o), 128'd4);
    chk("pop_drop_head", 128'(trace_order_o), 128'd25);

    // Clear alone, then clear colliding with a 1-record drop.
    step(2'b00, Z, Z, 1'b1, 1'b1);
    chk("clr_ovf", 128'(overflow_o), 128'd0);
    chk("clr_drop", 128'(drop_cnt_o), 128'd0);
    step(2'b11, mkrec(70), mkrec(71), 1'b0, 1'b0);
    step(2'b01, mkrec(72), Z, 1'b0, 1'b0);
    step(2'b01, mkrec(73), Z, 1'b0, 1'b1);
    chk("clr_drop_ovf", 128'(overflow_o), 128'd1);
    chk("clr_drop_cnt", 128'(drop_cnt_o), 128'd1);

    // Drain to 5 entries, then asynchronous reset with valid high.
    for (int i = 0; i < 11; i++) step(2'b00, Z, Z, 1'b1, 1'b0);
    chk("pre_rst_valid", 128'(trace_valid_o), 128'd1);
    commit_valid_i = 2'b11;
    trace_ready_i  = 1'b0;
    #2;
    rst_ni = 1'b0;
    model_reset();
    #1;
    chk("midrst_valid", 128'(trace_valid_o), 128'd0);
    chk("midrst_empty", 128'(empty_o), 128'd1);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    step(2'b11, mkrec(80), mkrec(81), 1'b0, 1'b0);
    chk("post_rst_order", 128'(trace_order_o), 128'd0);
    chk("post_rst_rec", trace_rec_o, mkrec(80));
    step(2'b00, Z, Z, 1'b1, 1'b0);
    chk("post_rst_order1", 128'(trace_order_o), 128'd1);
    step(2'b00, Z, Z, 1'b1, 1'b0);
    step(2'b00, Z, Z, 1'b1, 1'b0);

    done = 1'b1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
